// File: rtl/i2s_dac_tx.sv
// I2S slave-mode DAC transmitter: oversamples codec BCLK/LRCK on CLOCK_50 and
// serialises a one-deep buffered stereo pair MSB first with the I2S one-bit delay.
module i2s_dac_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              frame_start,
  output logic              underrun
);

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic                   bclk_dly_q, bclk_dly_d;
  logic                   lrck_dly_q, lrck_dly_d;
  logic                   bclk_fall_q, bclk_fall_d;
  logic                   lrck_prev_q, lrck_prev_d;
  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      right_pend_q, right_pend_d;
  logic [DATA_W-1:0]      hold_left_q, hold_left_d;
  logic [DATA_W-1:0]      hold_right_q, hold_right_d;
  logic                   full_q, full_d;
  logic                   dacdat_q, dacdat_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;
  logic                   lrck_chg, left_load, right_load;

  // Edge detection is registered, and LRCK is delayed by the same amount so both
  // pins, which the codec changes together, are judged at the same instant.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
    bclk_dly_d  = bclk_sync_q[SYNC_STAGES-1];
    lrck_dly_d  = lrck_sync_q[SYNC_STAGES-1];
    bclk_fall_d = bclk_dly_q & ~bclk_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    lrck_chg   = bclk_fall_q && (lrck_dly_q != lrck_prev_q);
    left_load  = lrck_chg && !lrck_dly_q;
    right_load = lrck_chg && lrck_dly_q && (state_q != WAIT_SYNC);

    state_d       = state_q;
    shift_d       = shift_q;
    right_pend_d  = right_pend_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    full_d        = full_q;
    dacdat_d      = dacdat_q;
    lrck_prev_d   = lrck_prev_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (bclk_fall_q) begin
      lrck_prev_d = lrck_dly_q;
      if (state_q == WAIT_SYNC) begin
        dacdat_d = 1'b0;
      end else begin
        dacdat_d = shift_q[DATA_W-1];
        shift_d  = shift_q << 1;
      end
      // Level decides the target channel, so a missed edge self-corrects.
      if (left_load) begin
        state_d       = LEFT;
        frame_start_d = 1'b1;
        if (full_q) begin
          shift_d      = hold_left_q;
          right_pend_d = hold_right_q;
          full_d       = 1'b0;
        end else begin
          shift_d      = '0;
          right_pend_d = '0;
          underrun_d   = 1'b1;
        end
      end else if (right_load) begin
        state_d = RIGHT;
        shift_d = right_pend_q;
      end
    end

    // Uses full_q: a same-cycle left load has already taken the old contents.
    if (in_valid && !full_q) begin
      hold_left_d  = in_left;
      hold_right_d = in_right;
      full_d       = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q   <= '0;
      lrck_sync_q   <= '0;
      bclk_dly_q    <= 1'b0;
      lrck_dly_q    <= 1'b0;
      bclk_fall_q   <= 1'b0;
      lrck_prev_q   <= 1'b0;
      state_q       <= WAIT_SYNC;
      shift_q       <= '0;
      right_pend_q  <= '0;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      full_q        <= 1'b0;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      bclk_sync_q   <= bclk_sync_d;
      lrck_sync_q   <= lrck_sync_d;
      bclk_dly_q    <= bclk_dly_d;
      lrck_dly_q    <= lrck_dly_d;
      bclk_fall_q   <= bclk_fall_d;
      lrck_prev_q   <= lrck_prev_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      right_pend_q  <= right_pend_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      full_q        <= full_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready    = ~full_q;
  assign AUD_DACLRCK = lrck_dly_q;
  assign AUD_DACDAT  = dacdat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: drives codec-style BCLK/LRCK (16 CLOCK_50 cycles per BCLK)
// and compares every cycle against a word/bit-index model of the I2S stream.
module tb_i2s_dac_tx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          bclk_pin, lrck_pin;
  logic [DW-1:0] in_left, in_right;
  logic          in_valid;
  logic          in_ready, dac_lrck, dac_dat, frame_start, underrun;

  always #10 clk = ~clk;

  i2s_dac_tx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .AUD_BCLK    (bclk_pin),
    .AUD_ADCLRCK (lrck_pin),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AUD_DACLRCK (dac_lrck),
    .AUD_DACDAT  (dac_dat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: current word and the index of the next bit to send.
  logic          m_synced, m_full, m_pin_prev, m_exp_dac;
  logic [DW-1:0] m_word, m_rpend, m_hl, m_hr;
  int            m_cnt;
  logic [DW-1:0] nxt_l, nxt_r;
  logic          cont_valid;
  int            frame_no;

  task automatic model_reset();
    m_synced = 1'b0; m_full = 1'b0; m_exp_dac = 1'b0;
    m_word = '0; m_rpend = '0; m_hl = '0; m_hr = '0; m_cnt = 0;
  endtask

  // One BCLK period starting at a pin falling edge. push_c / rst_c pick the
  // cycle whose following edge samples in_valid / reset (-1 = none).
  task automatic bclk_period(input logic lrck_val, input int push_c, input int rst_c);
    logic chg, do_left, do_right, bit_now, fs_exp, ur_exp, tr;
    chg        = (lrck_val != m_pin_prev);
    m_pin_prev = lrck_val;
    bclk_pin   = 1'b0;
    lrck_pin   = lrck_val;
    bit_now    = 1'b0;
    if (m_synced) begin
      if (m_cnt < DW) bit_now = m_word[DW-1-m_cnt];
      m_cnt++;
    end
    do_left  = chg && !lrck_val;
    do_right = chg && lrck_val && m_synced;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      fs_exp = 1'b0;
      ur_exp = 1'b0;
      if (reset) begin
        model_reset();
      end else begin
        tr = in_valid && !m_full;
        if (c == 4) begin
          m_exp_dac = bit_now;
          if (do_left) begin
            m_synced = 1'b1;
            fs_exp   = 1'b1;
            m_cnt    = 0;
            if (m_full) begin
              m_word = m_hl; m_rpend = m_hr; m_full = 1'b0;
            end else begin
              m_word = '0; m_rpend = '0; ur_exp = 1'b1;
            end
          end else if (do_right) begin
            m_word = m_rpend;
            m_cnt  = 0;
          end
        end
        if (tr) begin
          m_hl = in_left; m_hr = in_right; m_full = 1'b1;
        end
      end
      @(negedge clk);
      check("dacdat", {31'd0, dac_dat}, {31'd0, m_exp_dac});
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
      check("frame_start", {31'd0, frame_start}, {31'd0, fs_exp});
      check("underrun", {31'd0, underrun}, {31'd0, ur_exp});
      if (c == 7) check("daclrck", {31'd0, dac_lrck}, {31'd0, lrck_pin});
      reset    = (c == rst_c);
      in_valid = cont_valid || (c == push_c);
      in_left  = nxt_l;
      in_right = nxt_r;
      if (c == 8) bclk_pin = 1'b1;
    end
  endtask

  task automatic frame(input int slot, input bit push_r, input int left_push_c, input int rst_b);
    int rp_b;
    rp_b = (rst_b >= 0) ? rst_b + 1 : 2;
    for (int b = 0; b < slot; b++) bclk_period(1'b0, (b == 0) ? left_push_c : -1, -1);
    for (int b = 0; b < slot; b++)
      bclk_period(1'b1, (push_r && b == rp_b) ? 5 : -1, (b == rst_b) ? 10 : -1);
    frame_no++;
    $display("[TB] frame %0d slot=%0d done, tests=%0d failed=%0d", frame_no, slot, n_tests, n_fail);
  endtask

  task automatic rand_next();
    nxt_l = DW'($urandom);
    nxt_r = DW'($urandom);
  endtask

  initial begin
    reset = 1'b1; bclk_pin = 1'b1; lrck_pin = 1'b1;
    in_valid = 1'b0; in_left = '0; in_right = '0;
    cont_valid = 1'b0; frame_no = 0;
    nxt_l = '0; nxt_r = '0;
    model_reset();
    m_pin_prev = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dacdat", {31'd0, dac_dat}, 32'd0);
    check("rst_daclrck", {31'd0, dac_lrck}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Right half before the first LRCK fall: nothing may be serialised.
    nxt_l = 16'hA5C3; nxt_r = 16'h0F0F;
    for (int b = 0; b < 32; b++) bclk_period(1'b1, (b == 2) ? 5 : -1, -1);
    $display("[TB] pre-sync half done, tests=%0d failed=%0d", n_tests, n_fail);

    rand_next(); frame(32, 1, -1, -1);   // sends A5C3/0F0F
    rand_next(); frame(32, 1, -1, -1);
    frame(32, 0, -1, -1);                // no push: next frame underruns
    nxt_l = 16'h8001; nxt_r = 16'h7FFE;
    frame(32, 1, -1, -1);                // underrun frame, zeros

    // Slot equal to word width: LSB rides on the next channel's load edge.
    frame(16, 1, -1, -1);
    rand_next(); frame(16, 1, -1, -1);
    rand_next(); frame(16, 1, -1, -1);
    frame(16, 0, -1, -1);
    rand_next(); frame(16, 0, 3, -1);    // push lands on the load edge itself
    rand_next(); frame(16, 1, -1, -1);

    // Reset mid right channel, then a fresh pair for the re-synced frame.
    rand_next(); frame(32, 1, -1, 5);
    rand_next(); frame(32, 1, -1, -1);

    cont_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_next(); frame(32, 0, -1, -1);
    end
    cont_valid = 1'b0;
    frame(32, 0, -1, -1);
    frame(32, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

I2S slave-mode transmitter that serialises processed stereo samples onto the codec DAC data line. It runs entirely on CLOCK_50 and oversamples the codec-supplied AUD_BCLK and AUD_ADCLRCK, so the DAC frame is locked to the ADC frame. It sits between the distortion DSP outputs (dac_left/dac_right) and the AUD_DACDAT/AUD_DACLRCK pins. A one-deep holding buffer with a valid/ready handshake decouples the sample producer from the serial timing.

## Interface
- DATA_W, 16, sample width in bits; two's complement, MSB first.
- SYNC_STAGES, 2, flip-flop stages on AUD_BCLK and AUD_ADCLRCK (minimum 2).
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- AUD_BCLK  in  1  codec bit clock, asynchronous; maximum 6.25 MHz.
- AUD_ADCLRCK  in  1  codec frame clock, asynchronous; low = left, high = right.
- in_left  in  DATA_W  left sample offered.
- in_right  in  DATA_W  right sample offered.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding buffer empty; a transfer occurs when in_valid & in_ready.
- AUD_DACLRCK  out  1  registered copy of the synchronised AUD_ADCLRCK.
- AUD_DACDAT  out  1  serial data; changes only after a detected BCLK falling edge.
- frame_start  out  1  one-cycle pulse when a left word is loaded.
- underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty.

## Operation
- Synchronise BCLK and LRCK through SYNC_STAGES FFs, then one further register each for edge detection. The event bclk_fall is synced BCLK 1→0. All serial actions occur only on bclk_fall.
- State machine: WAIT_SYNC, LEFT, RIGHT. Reset enters WAIT_SYNC.
  - WAIT_SYNC: AUD_DACDAT held 0. On a bclk_fall where synced LRCK differs from lrck_prev and is now 0, do a left load and go to LEFT. A rising LRCK change is ignored here.
  - LEFT: on a bclk_fall with an LRCK change to 1, do a right load and go to RIGHT.
  - RIGHT: on a bclk_fall with an LRCK change to 0, do a left load and go to LEFT.
  - lrck_prev updates on every bclk_fall.
- Every bclk_fall in LEFT/RIGHT, including load edges: AUD_DACDAT <= shift[DATA_W-1]. Then shift <= shift << 1 with zero fill.
  - Load edges instead write the new word into shift after sampling the old MSB. This gives the standard I2S one-BCLK delay: the load edge outputs the previous word's next bit (its LSB when the slot is exactly DATA_W wide, otherwise 0).
  - The new MSB goes out on the following bclk_fall. Slots longer than DATA_W are padded with 0.
- Left load:
  - If the holding buffer is full: shift <= hold_left, right_pend <= hold_right, buffer marked empty.
  - If empty: shift <= 0, right_pend <= 0, underrun pulses.
  - frame_start pulses in either case.
- Right load: shift <= right_pend. The holding buffer is untouched.
- in_ready = buffer empty. A transfer writes hold_left/hold_right and marks the buffer full.
  - If a transfer and a left load occur in the same cycle, the load takes the old contents (or zeros if empty). The transfer then fills the buffer for the next frame. in_ready was 1 that cycle, so there is no conflict.
- An LRCK change outside a bclk_fall is not acted on until the next bclk_fall.
- An LRCK change to the same level as the current state (glitch or missed edge) re-enters the correct state by level: a change to 0 always does a left load, a change to 1 always does a right load.

## Timing
- Reset values: AUD_DACDAT 0, AUD_DACLRCK 0, in_ready 1, frame_start 0, underrun 0, shift/right_pend/hold 0, buffer empty, state WAIT_SYNC.
- Reset mid-frame: all of the above apply on the next cycle. Pending data is discarded. Re-sync happens on the next falling LRCK.
- Latency from pin BCLK fall to AUD_DACDAT change: SYNC_STAGES+2 CLOCK_50 cycles (4 at default, 80 ns).
- Latency from pin LRCK change to AUD_DACLRCK change: SYNC_STAGES+1 cycles.
- frame_start and underrun are asserted in the same cycle that AUD_DACDAT is updated for the load edge.
- Minimum of 8 CLOCK_50 cycles per BCLK period is required. No behaviour is defined below that.

## Test plan
- Reset, BCLK 3.125 MHz, 32 BCLK per LRCK half. Push L=16'hA5C3, R=16'h0F0F before the first left frame. Required: nothing serialised until the first LRCK fall. The next 16 DACDAT bits after the 1-bit delay are A5C3 MSB-first, followed by 16 zeros. The right half carries 0F0F the same way. frame_start pulses once per frame.
- Keep in_valid low for one frame. Required: underrun pulses at that left load, and the whole frame transmits zeros.
- 16 BCLK per half (slot = DATA_W), consecutive pairs 8001/7FFE. Required: each word's LSB appears on the load edge of the next channel, and no bit is dropped or duplicated.
- Assert in_valid with new data in the exact cycle of a left load while the buffer is empty. Required: the current frame transmits zeros with underrun, and the next frame transmits the new data.
- Assert reset for 1 cycle mid-right-channel. Required: AUD_DACDAT is 0 the next cycle and in_ready is 1. Transmission resumes only at the next LRCK fall, with correct alignment.
- Hold in_valid high continuously. Required: in_ready deasserts after the transfer and reasserts for exactly one cycle after each left load. One pair is consumed per frame.
